// File: rtl/uart_prog_loader_pkg.sv
// Shared types and constants for the UART program/data loader.
package uart_prog_loader_pkg;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_CNT_LO,
        LD_CNT_HI,
        LD_DATA,
        LD_DONE
    } ld_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    localparam logic [7:0] HDR_INST = 8'h49;
    localparam logic [7:0] HDR_DATA = 8'h44;
    localparam int         WORD_W   = 32;

endpackage

// File: rtl/uart_prog_loader_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer, mid-bit sampling, stop-bit check.
module uart_rx_byte
    import uart_prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_data_o,
    output logic       frame_err_o
);

    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    rx_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          rx_meta_q, rx_sync_q, rx_prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        if (state_q != RX_IDLE && cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
        case (state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    cnt_d   = HALF;
                    state_d = RX_START;
                end
            end
            RX_START: begin
                if (cnt_q == '0) begin
                    if (rx_sync_q) begin
                        state_d = RX_IDLE;
                    end else begin
                        cnt_d   = FULL;
                        bit_d   = '0;
                        state_d = RX_DATA;
                    end
                end
            end
            RX_DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    cnt_d   = FULL;
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            RX_STOP: begin
                // Back to idle at the stop mid-sample so a start bit right after is caught.
                if (cnt_q == '0) begin
                    valid_d = rx_sync_q;
                    ferr_d  = !rx_sync_q;
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign byte_valid_o = valid_q;
    assign byte_data_o  = shift_q;
    assign frame_err_o  = ferr_q;

endmodule

// File: rtl/uart_prog_loader.sv
// Frame loader: header, 16-bit word count, little-endian words written to imem/dmem.
//   state     | meaning
//   LD_IDLE   | waiting for 'I' or 'D' header byte
//   LD_CNT_LO | expecting count low byte
//   LD_CNT_HI | expecting count high byte
//   LD_DATA   | assembling words, issuing writes
//   LD_DONE   | one-cycle completion pulse
module uart_prog_loader
    import uart_prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_WIDTH   = 14
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  rx_i,
    output logic                  mem_we_o,
    output logic                  mem_sel_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [WORD_W-1:0]     mem_wdata_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       frame_err;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .rx_i         (rx_i),
        .byte_valid_o (byte_valid),
        .byte_data_o  (byte_data),
        .frame_err_o  (frame_err)
    );

    ld_state_t             state_q, state_d;
    logic                  sel_q, sel_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WORD_W-1:0]     wdata_q, wdata_d;
    logic [23:0]           word_q, word_d;
    logic [1:0]            idx_q, idx_d;
    logic [15:0]           count_q, count_d;
    logic                  we_q, we_d;
    logic                  err_q, err_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= LD_IDLE;
            sel_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
            idx_q   <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            we_q    <= we_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        word_d  = word_q;
        idx_d   = idx_q;
        count_d = count_q;
        we_d    = 1'b0;
        err_d   = err_q;
        if (we_q) begin
            addr_d = addr_q + ADDR_WIDTH'(1);
        end
        case (state_q)
            LD_IDLE: begin
                if (frame_err) begin
                    err_d = 1'b1;
                end
                if (byte_valid && (byte_data == HDR_INST || byte_data == HDR_DATA)) begin
                    sel_d   = (byte_data == HDR_DATA);
                    addr_d  = '0;
                    err_d   = 1'b0;
                    idx_d   = '0;
                    state_d = LD_CNT_LO;
                end
            end
            LD_CNT_LO: begin
                if (byte_valid) begin
                    count_d = {8'h00, byte_data};
                    state_d = LD_CNT_HI;
                end
            end
            LD_CNT_HI: begin
                if (byte_valid) begin
                    count_d = {byte_data, count_q[7:0]};
                    state_d = (byte_data == 8'h00 && count_q[7:0] == 8'h00) ? LD_DONE : LD_DATA;
                end
            end
            LD_DATA: begin
                if (byte_valid) begin
                    if (idx_q == 2'd3) begin
                        wdata_d = {byte_data, word_q};
                        we_d    = 1'b1;
                        count_d = count_q - 16'd1;
                        idx_d   = '0;
                    end else begin
                        word_d = {byte_data, word_q[23:8]};
                        idx_d  = idx_q + 2'd1;
                    end
                end else if (we_q && count_q == 16'd0) begin
                    state_d = LD_DONE;
                end
            end
            LD_DONE: state_d = LD_IDLE;
            default: state_d = LD_IDLE;
        endcase
        if (frame_err && state_q != LD_IDLE) begin
            state_d = LD_IDLE;
            err_d   = 1'b1;
            we_d    = 1'b0;
        end
    end

    assign mem_we_o    = we_q;
    assign mem_sel_o   = sel_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign busy_o      = (state_q != LD_IDLE);
    assign done_o      = (state_q == LD_DONE);
    assign err_o       = err_q;

endmodule
